periph_plug_arbiter: RTL and testbench
======================================

# periph_plug_arbiter

Cluster peripheral interconnect controller. It decodes each core's peripheral request by its plug-ID address field and arbitrates round-robin among cores contending for the same peripheral slave plug (EOC, timer, event unit, HWPE, icache ctrl, DMA, external). It routes the fixed-latency response back to the granted core, and answers accesses to unmapped plugs with an error response. It sits between the cores' peripheral demux outputs and the peripheral slave plugs.

## Interface
Parameters:
- NB_MASTER, 4, number of requesting cores (≥2)
- NB_SLAVE, 8, number of slave plugs (power of 2)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- ROUTE_LSB, 10, LSB of the plug-ID field; field width is log2(NB_SLAVE)

Ports (clock and reset first; `[M]`/`[S]` = unpacked per master/slave):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- m_req_i[M]  in  1  request
- m_add_i[M]  in  ADDR_WIDTH  address
- m_wen_i[M]  in  1  1 = read, 0 = write
- m_wdata_i[M]  in  DATA_WIDTH  write data
- m_be_i[M]  in  DATA_WIDTH/8  byte enables
- m_gnt_o[M]  out  1  grant
- m_r_valid_o[M]  out  1  response valid
- m_r_rdata_o[M]  out  DATA_WIDTH  read data
- m_r_opc_o[M]  out  1  1 = error
- s_req_o[S]  out  1  request to plug
- s_add_o[S], s_wen_o[S], s_wdata_o[S], s_be_o[S]  out  as master  forwarded from the winning master
- s_id_o[S]  out  log2(NB_MASTER)  winning master index
- s_gnt_i[S]  in  1  plug grant
- s_r_valid_i[S]  in  1  plug response, exactly 1 cycle after handshake
- s_r_rdata_i[S]  in  DATA_WIDTH  read data
- s_r_opc_i[S]  in  1  plug error

## Operation
- Decode: target = m_add_i[ROUTE_LSB +: log2(NB_SLAVE)]. Plug SPER_UNMAPPED_ID (3) is unmapped; its s_req_o is tied 0.
- Per plug: one round-robin arbiter with pointer ptr (reset 0). Winner = first requesting master at index ≥ ptr, wrapping around. s_req_o is driven from the winner, s_id_o = winner.
- m_gnt_o[i] = (i is the winner of its target) & s_gnt_i[target]. Non-winners see gnt = 0 and must hold their request.
- On handshake (s_req_o & s_gnt_i), ptr ← (winner+1) mod NB_MASTER. With no handshake, ptr holds. A plug withholding gnt does not advance ptr.
- Response tracking: per plug, register rsp_valid and rsp_id on handshake. At the next cycle, when s_r_valid_i is asserted, route s_r_rdata_i/s_r_opc_i to master rsp_id with m_r_valid_o = 1.
- Unmapped access: the requesting master is granted in the same cycle with no arbitration (error path arbitrates by lowest index only when the same master requests, which is at most one request per master per cycle). The next cycle gives m_r_valid_o = 1, m_r_opc_o = 1, m_r_rdata_o = UNMAPPED_RDATA (32'hBADACCE5).
- A master has at most one response per cycle, because it has at most one handshake per cycle and latency is fixed.
- s_r_valid_i without a registered handshake is ignored and flagged by an assertion.

## Timing
- Reset values: all m_gnt_o, m_r_valid_o, m_r_opc_o, s_req_o = 0. All rdata, add, wdata, be, id outputs = 0. All ptr = 0, rsp_valid = 0.
- Request to s_req_o: combinational (0 cycles). m_gnt_o: combinational from s_gnt_i.
- Response: m_r_valid_o asserted in cycle t+1 for a handshake in cycle t, combinational from s_r_valid_i.
- Back-to-back handshakes on the same plug every cycle are supported, with full throughput.
- Reset asserted mid-transaction clears all pending responses. A plug response arriving after reset deassertion is dropped.
- No combinational path exists from s_r_valid_i to any s_req_o or m_gnt_o.

## Structure
- pulp_cluster_package: add NB_SPERIPH_PLUGS = 8, SPER_UNMAPPED_ID = 3, and UNMAPPED_RDATA. Reuse the existing SPER_*_ID constants for plug indexing in the bench.
- Sub-module periph_rr_arb (NB_REQ parameter): req vector, gnt in, winner index out, and pointer register. Instantiated NB_SLAVE times via generate; the unmapped plug instance is replaced by the error responder.

## Test plan
- Single master 0 reads timer (addr[12:10] = 1), s_gnt_i = 1, rdata 32'h1234 → m_gnt_o[0] in cycle 0, m_r_valid_o[0] with 32'h1234 in cycle 1.
- Masters 0–3 request EOC continuously with gnt always 1 → grants in order 0, 1, 2, 3, 0, and each master's response in the following cycle.
- Masters 1 and 2 request the event unit while s_gnt_i = 0 for 3 cycles → no m_gnt_o and ptr unchanged. Then gnt = 1 → master 1 is granted first, then master 2.
- Master 2 accesses plug 3 → gnt in the same cycle; next cycle r_valid = 1, r_opc = 1, rdata = 32'hBADACCE5. No s_req_o is toggled.
- Master 0 targets DMA and master 1 targets HWPE in the same cycle → both granted; responses go to the correct masters in the next cycle.
- rst_ni is pulsed low between handshake and response → all outputs return to 0, the late s_r_valid_i is dropped, and ptrs = 0.

Source files
------------

// File: rtl/periph_plug_arbiter_pkg.sv
// Shared constants for the cluster peripheral interconnect: plug indices,
// the unmapped plug and the data returned on an unmapped access.
package periph_plug_arbiter_pkg;

   localparam int NB_SPERIPH_PLUGS    = 8;

   localparam int SPER_EOC_ID         = 0;
   localparam int SPER_TIMER_ID       = 1;
   localparam int SPER_EVENT_U_ID     = 2;
   localparam int SPER_UNMAPPED_ID    = 3;
   localparam int SPER_HWPE_ID        = 4;
   localparam int SPER_ICACHE_CTRL_ID = 5;
   localparam int SPER_DMA_ID         = 6;
   localparam int SPER_EXT_ID         = 7;

   localparam logic [31:0] UNMAPPED_RDATA = 32'hBADACCE5;

endpackage

// File: rtl/periph_rr_arb.sv
// Round-robin arbiter for one peripheral plug: the first requester at or after
// the pointer wins; the pointer moves past the winner only on a handshake.
module periph_rr_arb #(
   parameter int NB_REQ = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NB_REQ-1:0]         req_i,
   input  logic                      gnt_i,
   output logic                      valid_o,
   output logic [$clog2(NB_REQ)-1:0] winner_o
);

   localparam int IW = $clog2(NB_REQ);

   logic [IW-1:0] r_ptr;
   logic [IW-1:0] w_idx;

   // Scan from the farthest candidate back to the pointer so the closest one wins.
   always_comb begin
      winner_o = '0;
      w_idx    = '0;
      for (int k = NB_REQ - 1; k >= 0; k--) begin
         w_idx = IW'((int'(r_ptr) + k) % NB_REQ);
         if (req_i[w_idx]) begin
            winner_o = w_idx;
         end
      end
   end

   assign valid_o = |req_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr <= '0;
      end else if (valid_o && gnt_i) begin
         r_ptr <= (winner_o == IW'(NB_REQ - 1)) ? '0 : winner_o + 1'b1;
      end
   end

endmodule

// File: rtl/periph_plug_arbiter.sv
// Cluster peripheral interconnect: decodes each core's plug ID, arbitrates per
// plug round-robin, routes fixed-latency responses and error-answers the unmapped plug.
module periph_plug_arbiter
   import periph_plug_arbiter_pkg::*;
#(
   parameter int NB_MASTER  = 4,
   parameter int NB_SLAVE   = NB_SPERIPH_PLUGS,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ROUTE_LSB  = 10
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         m_req_i     [NB_MASTER],
   input  logic [ADDR_WIDTH-1:0]        m_add_i     [NB_MASTER],
   input  logic                         m_wen_i     [NB_MASTER],
   input  logic [DATA_WIDTH-1:0]        m_wdata_i   [NB_MASTER],
   input  logic [DATA_WIDTH/8-1:0]      m_be_i      [NB_MASTER],
   output logic                         m_gnt_o     [NB_MASTER],
   output logic                         m_r_valid_o [NB_MASTER],
   output logic [DATA_WIDTH-1:0]        m_r_rdata_o [NB_MASTER],
   output logic                         m_r_opc_o   [NB_MASTER],
   output logic                         s_req_o     [NB_SLAVE],
   output logic [ADDR_WIDTH-1:0]        s_add_o     [NB_SLAVE],
   output logic                         s_wen_o     [NB_SLAVE],
   output logic [DATA_WIDTH-1:0]        s_wdata_o   [NB_SLAVE],
   output logic [DATA_WIDTH/8-1:0]      s_be_o      [NB_SLAVE],
   output logic [$clog2(NB_MASTER)-1:0] s_id_o      [NB_SLAVE],
   input  logic                         s_gnt_i     [NB_SLAVE],
   input  logic                         s_r_valid_i [NB_SLAVE],
   input  logic [DATA_WIDTH-1:0]        s_r_rdata_i [NB_SLAVE],
   input  logic                         s_r_opc_i   [NB_SLAVE]
);

   localparam int MW = $clog2(NB_MASTER);
   localparam int SW = $clog2(NB_SLAVE);

   logic [SW-1:0]        w_tgt     [NB_MASTER];
   logic [NB_MASTER-1:0] w_req_vec [NB_SLAVE];
   logic [NB_MASTER-1:0] w_gnt_vec [NB_SLAVE];
   logic [NB_MASTER-1:0] w_rsp_hit [NB_SLAVE];
   logic [NB_MASTER-1:0] r_err_pend;
   logic                 r_post_rst;

   genvar gi;

   for (gi = 0; gi < NB_MASTER; gi++) begin : g_decode
      assign w_tgt[gi] = m_add_i[gi][ROUTE_LSB +: SW];
   end

   always_comb begin
      for (int s = 0; s < NB_SLAVE; s++) begin
         for (int m = 0; m < NB_MASTER; m++) begin
            w_req_vec[s][m] = m_req_i[m] && (w_tgt[m] == SW'(s));
         end
      end
   end

   // Low for the first cycle after reset, when a plug may still answer a dropped handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_post_rst <= 1'b0;
      end else begin
         r_post_rst <= 1'b1;
      end
   end

   for (gi = 0; gi < NB_SLAVE; gi++) begin : g_plug
      if (gi == SPER_UNMAPPED_ID) begin : g_err
         logic w_unused_err;

         // Every master hitting the hole is granted at once and answered next cycle.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               r_err_pend <= '0;
            end else begin
               r_err_pend <= w_req_vec[gi];
            end
         end

         assign w_gnt_vec[gi]  = w_req_vec[gi];
         assign w_rsp_hit[gi]  = '0;
         assign s_req_o[gi]    = 1'b0;
         assign s_add_o[gi]    = '0;
         assign s_wen_o[gi]    = 1'b0;
         assign s_wdata_o[gi]  = '0;
         assign s_be_o[gi]     = '0;
         assign s_id_o[gi]     = '0;
         assign w_unused_err   = ^{s_gnt_i[gi], s_r_valid_i[gi], s_r_opc_i[gi], s_r_rdata_i[gi]};
      end else begin : g_arb
         logic          w_valid;
         logic [MW-1:0] w_winner;
         logic          w_hs;
         logic          r_rsp_valid;
         logic [MW-1:0] r_rsp_id;

         periph_rr_arb #(
            .NB_REQ (NB_MASTER)
         ) u_arb (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .req_i    (w_req_vec[gi]),
            .gnt_i    (s_gnt_i[gi]),
            .valid_o  (w_valid),
            .winner_o (w_winner)
         );

         assign w_hs          = w_valid && s_gnt_i[gi];
         assign s_req_o[gi]   = w_valid;
         assign s_add_o[gi]   = w_valid ? m_add_i[w_winner]   : '0;
         assign s_wen_o[gi]   = w_valid ? m_wen_i[w_winner]   : 1'b0;
         assign s_wdata_o[gi] = w_valid ? m_wdata_i[w_winner] : '0;
         assign s_be_o[gi]    = w_valid ? m_be_i[w_winner]    : '0;
         assign s_id_o[gi]    = w_valid ? w_winner : '0;
         assign w_gnt_vec[gi] = w_hs ? (NB_MASTER'(1) << w_winner) : '0;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               r_rsp_valid <= 1'b0;
               r_rsp_id    <= '0;
            end else begin
               r_rsp_valid <= w_hs;
               if (w_hs) begin
                  r_rsp_id <= w_winner;
               end
            end
         end

         // Only a response that matches a registered handshake reaches a master.
         assign w_rsp_hit[gi] = (r_rsp_valid && s_r_valid_i[gi]) ? (NB_MASTER'(1) << r_rsp_id) : '0;

         a_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (r_post_rst && s_r_valid_i[gi]) |-> r_rsp_valid);
      end
   end

   always_comb begin
      for (int m = 0; m < NB_MASTER; m++) begin
         m_gnt_o[m]     = 1'b0;
         m_r_valid_o[m] = r_err_pend[m];
         m_r_opc_o[m]   = r_err_pend[m];
         m_r_rdata_o[m] = r_err_pend[m] ? DATA_WIDTH'(UNMAPPED_RDATA) : '0;
         for (int s = 0; s < NB_SLAVE; s++) begin
            if (w_gnt_vec[s][m]) begin
               m_gnt_o[m] = 1'b1;
            end
            if (w_rsp_hit[s][m]) begin
               m_r_valid_o[m] = 1'b1;
               m_r_rdata_o[m] = s_r_rdata_i[s];
               m_r_opc_o[m]   = s_r_opc_i[s];
            end
         end
      end
   end

endmodule

// File: tb/tb_periph_plug_arbiter.sv
// Scoreboard bench for periph_plug_arbiter: a plug-level reference model predicts
// grants, forwarded requests and responses; a monitor compares them every cycle.
module tb_periph_plug_arbiter;
   import periph_plug_arbiter_pkg::*;

   localparam int NM        = 4;
   localparam int NS        = 8;
   localparam int MW        = 2;
   localparam int ROUTE_LSB = 10;

   logic          clk_i;
   logic          rst_ni;
   logic          m_req_i     [NM];
   logic [31:0]   m_add_i     [NM];
   logic          m_wen_i     [NM];
   logic [31:0]   m_wdata_i   [NM];
   logic [3:0]    m_be_i      [NM];
   logic          m_gnt_o     [NM];
   logic          m_r_valid_o [NM];
   logic [31:0]   m_r_rdata_o [NM];
   logic          m_r_opc_o   [NM];
   logic          s_req_o     [NS];
   logic [31:0]   s_add_o     [NS];
   logic          s_wen_o     [NS];
   logic [31:0]   s_wdata_o   [NS];
   logic [3:0]    s_be_o      [NS];
   logic [MW-1:0] s_id_o      [NS];
   logic          s_gnt_i     [NS];
   logic          s_r_valid_i [NS];
   logic [31:0]   s_r_rdata_i [NS];
   logic          s_r_opc_i   [NS];

   periph_plug_arbiter #(
      .NB_MASTER  (NM),
      .NB_SLAVE   (NS),
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .ROUTE_LSB  (ROUTE_LSB)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .m_req_i     (m_req_i),
      .m_add_i     (m_add_i),
      .m_wen_i     (m_wen_i),
      .m_wdata_i   (m_wdata_i),
      .m_be_i      (m_be_i),
      .m_gnt_o     (m_gnt_o),
      .m_r_valid_o (m_r_valid_o),
      .m_r_rdata_o (m_r_rdata_o),
      .m_r_opc_o   (m_r_opc_o),
      .s_req_o     (s_req_o),
      .s_add_o     (s_add_o),
      .s_wen_o     (s_wen_o),
      .s_wdata_o   (s_wdata_o),
      .s_be_o      (s_be_o),
      .s_id_o      (s_id_o),
      .s_gnt_i     (s_gnt_i),
      .s_r_valid_i (s_r_valid_i),
      .s_r_rdata_i (s_r_rdata_i),
      .s_r_opc_i   (s_r_opc_i)
   );

   typedef struct {
      int                    cyc;
      logic [NM-1:0]         gnt;
      logic [NS-1:0]         sreq;
      logic [NS-1:0][MW-1:0] sid;
      logic [NS-1:0][31:0]   sadd;
      logic [NS-1:0][31:0]   swdata;
      logic [NS-1:0]         swen;
   } cyc_exp_t;

   typedef struct {
      int          cyc;
      logic [31:0] rdata;
      logic        opc;
   } rsp_t;

   cyc_exp_t    cyc_q [$];
   rsp_t        rsp_q [NM][$];

   // Stimulus state per master / plug and the plug-level reference state.
   logic        b_req   [NM];
   int          b_tgt   [NM];
   logic [31:0] b_add   [NM];
   logic        b_wen   [NM];
   logic [31:0] b_wdata [NM];
   logic [3:0]  b_be    [NM];
   logic        b_sgnt  [NS];
   int          ptr     [NS];
   logic        pv      [NS];
   logic [31:0] prd     [NS];
   logic        pop     [NS];
   logic [NM-1:0] last_gnt;
   logic        use_fixed;
   logic [31:0] fixed_rdata;

   int cyc;
   int n_checks;
   int n_errors;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      logic [NM-1:0] gv, rv, ov;
      logic [NS-1:0] sv;
      logic [31:0]   acc;
      acc = '0;
      for (int i = 0; i < NM; i++) begin
         gv[i] = m_gnt_o[i];
         rv[i] = m_r_valid_o[i];
         ov[i] = m_r_opc_o[i];
         acc   = acc | m_r_rdata_o[i];
      end
      for (int s = 0; s < NS; s++) begin
         sv[s] = s_req_o[s];
         acc   = acc | s_add_o[s] | s_wdata_o[s] | 32'(s_be_o[s]) | 32'(s_id_o[s]) | 32'(s_wen_o[s]);
      end
      check({tag, "_gnt"}, 64'(gv), 64'(0));
      check({tag, "_rvalid"}, 64'(rv), 64'(0));
      check({tag, "_ropc"}, 64'(ov), 64'(0));
      check({tag, "_sreq"}, 64'(sv), 64'(0));
      check({tag, "_data"}, 64'(acc), 64'(0));
   endtask

   task automatic set_req(input int i, input int t);
      logic [31:0] a;
      a = $urandom;
      a[ROUTE_LSB +: 3] = 3'(t);
      b_req[i]   = 1'b1;
      b_tgt[i]   = t;
      b_add[i]   = a;
      b_wen[i]   = 1'($urandom_range(0, 1));
      b_wdata[i] = $urandom;
      b_be[i]    = 4'($urandom);
   endtask

   task automatic idle_all();
      for (int i = 0; i < NM; i++) b_req[i] = 1'b0;
      for (int s = 0; s < NS; s++) b_sgnt[s] = 1'b1;
   endtask

   // One bus cycle: drive inputs after the edge, then predict the cycle's outcome.
   task automatic step(input bit rst_pulse);
      cyc_exp_t e;
      int       w;
      int       m;
      @(posedge clk_i);
      #1;
      if (rst_pulse) begin
         for (int i = 0; i < NM; i++) m_req_i[i] = 1'b0;
         for (int s = 0; s < NS; s++) begin
            s_gnt_i[s]     = 1'b0;
            s_r_valid_i[s] = 1'b0;
         end
         rst_ni = 1'b0;
         #1;
         check_idle_outputs("midrst");
         rst_ni = 1'b1;
         for (int s = 0; s < NS; s++) ptr[s] = 0;
         for (int i = 0; i < NM; i++) rsp_q[i].delete();
      end
      cyc++;
      for (int s = 0; s < NS; s++) begin
         s_r_valid_i[s] = pv[s];
         s_r_rdata_i[s] = prd[s];
         s_r_opc_i[s]   = pop[s];
         pv[s]          = 1'b0;
         s_gnt_i[s]     = b_sgnt[s];
      end
      for (int i = 0; i < NM; i++) begin
         m_req_i[i]   = b_req[i];
         m_add_i[i]   = b_add[i];
         m_wen_i[i]   = b_wen[i];
         m_wdata_i[i] = b_wdata[i];
         m_be_i[i]    = b_be[i];
      end
      e.cyc = cyc;
      e.gnt = '0;
      e.sreq = '0;
      e.sid = '0;
      e.sadd = '0;
      e.swdata = '0;
      e.swen = '0;
      for (int s = 0; s < NS; s++) begin
         if (s == SPER_UNMAPPED_ID) begin
            for (int i = 0; i < NM; i++) begin
               if (b_req[i] && b_tgt[i] == s) begin
                  e.gnt[i] = 1'b1;
                  rsp_q[i].push_back('{cyc + 1, UNMAPPED_RDATA, 1'b1});
               end
            end
         end else begin
            w = -1;
            for (int k = 0; k < NM; k++) begin
               m = (ptr[s] + k) % NM;
               if (w < 0 && b_req[m] && b_tgt[m] == s) w = m;
            end
            if (w >= 0) begin
               e.sreq[s]   = 1'b1;
               e.sid[s]    = MW'(w);
               e.sadd[s]   = b_add[w];
               e.swdata[s] = b_wdata[w];
               e.swen[s]   = b_wen[w];
               if (b_sgnt[s]) begin
                  e.gnt[w] = 1'b1;
                  ptr[s]   = (w + 1) % NM;
                  pv[s]    = 1'b1;
                  prd[s]   = use_fixed ? fixed_rdata : $urandom;
                  pop[s]   = use_fixed ? 1'b0 : 1'($urandom_range(0, 1));
                  rsp_q[w].push_back('{cyc + 1, prd[s], pop[s]});
               end
            end
         end
      end
      cyc_q.push_back(e);
      last_gnt = e.gnt;
   endtask

   task automatic monitor_cycle();
      cyc_exp_t      e;
      rsp_t          r;
      logic [NM-1:0] gv;
      logic [NS-1:0] sv;
      if (cyc_q.size() > 0) begin
         e = cyc_q.pop_front();
         for (int i = 0; i < NM; i++) gv[i] = m_gnt_o[i];
         for (int s = 0; s < NS; s++) sv[s] = s_req_o[s];
         check("m_gnt", 64'(gv), 64'(e.gnt));
         check("s_req", 64'(sv), 64'(e.sreq));
         for (int s = 0; s < NS; s++) begin
            if (e.sreq[s]) begin
               check($sformatf("s_id[%0d]", s), 64'(s_id_o[s]), 64'(e.sid[s]));
               check($sformatf("s_add[%0d]", s), 64'(s_add_o[s]), 64'(e.sadd[s]));
               check($sformatf("s_wdata[%0d]", s), 64'(s_wdata_o[s]), 64'(e.swdata[s]));
               check($sformatf("s_wen[%0d]", s), 64'(s_wen_o[s]), 64'(e.swen[s]));
            end
         end
      end
      for (int i = 0; i < NM; i++) begin
         if (m_r_valid_o[i]) begin
            if (rsp_q[i].size() == 0 || rsp_q[i][0].cyc != cyc) begin
               n_checks++;
               n_errors++;
               $display("FAIL rsp_unexpected m%0d: got r_valid=1 rdata=%08h, expected no response (cycle %0d)",
                        i, m_r_rdata_o[i], cyc);
            end else begin
               r = rsp_q[i].pop_front();
               check($sformatf("rsp_rdata m%0d", i), 64'(m_r_rdata_o[i]), 64'(r.rdata));
               check($sformatf("rsp_opc m%0d", i), 64'(m_r_opc_o[i]), 64'(r.opc));
               $display("rsp m%0d cyc %0d rdata %08h opc %0b", i, cyc, m_r_rdata_o[i], m_r_opc_o[i]);
            end
         end else if (rsp_q[i].size() > 0 && rsp_q[i][0].cyc <= cyc) begin
            r = rsp_q[i].pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL rsp_missing m%0d: got r_valid=0, expected rdata=%08h (cycle %0d)", i, r.rdata, cyc);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk_i);
         monitor_cycle();
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0;
      n_checks = 0;
      n_errors = 0;
      use_fixed = 1'b0;
      fixed_rdata = '0;
      last_gnt = '0;
      rst_ni = 1'b0;
      for (int i = 0; i < NM; i++) begin
         b_req[i] = 1'b0; b_tgt[i] = 0; b_add[i] = '0; b_wen[i] = 1'b0;
         b_wdata[i] = '0; b_be[i] = '0;
         m_req_i[i] = 1'b0; m_add_i[i] = '0; m_wen_i[i] = 1'b0;
         m_wdata_i[i] = '0; m_be_i[i] = '0;
      end
      for (int s = 0; s < NS; s++) begin
         b_sgnt[s] = 1'b0; ptr[s] = 0; pv[s] = 1'b0; prd[s] = '0; pop[s] = 1'b0;
         s_gnt_i[s] = 1'b0; s_r_valid_i[s] = 1'b0; s_r_rdata_i[s] = '0; s_r_opc_i[s] = 1'b0;
      end
      #12;
      check_idle_outputs("reset");
      rst_ni = 1'b1;

      // Single read of the timer with a known data word.
      idle_all();
      use_fixed = 1'b1;
      fixed_rdata = 32'h0000_1234;
      set_req(0, SPER_TIMER_ID);
      b_wen[0] = 1'b1;
      step(0);
      idle_all();
      step(0);
      use_fixed = 1'b0;

      // All masters hammer the EOC plug with grant always high.
      for (int i = 0; i < NM; i++) set_req(i, SPER_EOC_ID);
      repeat (5) step(0);
      idle_all();
      step(0);

      // Event unit withholds grant, then releases it.
      set_req(1, SPER_EVENT_U_ID);
      set_req(2, SPER_EVENT_U_ID);
      b_sgnt[SPER_EVENT_U_ID] = 1'b0;
      repeat (3) step(0);
      b_sgnt[SPER_EVENT_U_ID] = 1'b1;
      step(0);
      b_req[1] = 1'b0;
      step(0);
      idle_all();
      step(0);

      // Unmapped plug access.
      set_req(2, SPER_UNMAPPED_ID);
      step(0);
      idle_all();
      step(0);

      // Two masters on two different plugs in parallel.
      set_req(0, SPER_DMA_ID);
      set_req(1, SPER_HWPE_ID);
      step(0);
      idle_all();
      step(0);

      // Reset between handshake and response; the late response must vanish.
      set_req(0, SPER_EOC_ID);
      step(0);
      idle_all();
      step(1);
      set_req(0, SPER_EOC_ID);
      set_req(1, SPER_EOC_ID);
      step(0);
      b_req[0] = 1'b0;
      step(0);
      idle_all();
      step(0);

      // Randomized traffic; a stalled master keeps its request unchanged.
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NM; i++) begin
            if (!b_req[i] || last_gnt[i]) begin
               if ($urandom_range(0, 9) < 6) set_req(i, int'($urandom_range(0, 7)));
               else b_req[i] = 1'b0;
            end
         end
         for (int s = 0; s < NS; s++) b_sgnt[s] = ($urandom_range(0, 9) < 7);
         step(0);
      end
      idle_all();
      step(0);
      step(0);
      @(negedge clk_i);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
